serial_subtractor: RTL

- Bit-serial N-bit subtractor. Computes a - b - bin, LSB first, one bit per clock through a single full-subtractor cell with a registered borrow.
- Sits one stage above the gate-level full subtractor cell: it sequences operands into the cell and accumulates its diff/borrow outputs into a word result.
- The block trades area for latency and uses a start/busy/done handshake.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 93 +++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master issues operations and the slave (the subtractor) returns results.
interface serial_subtractor_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: a - b - bin, LSB first, one full-subtractor
// step per clock with a registered borrow and a start/busy/done handshake.
module serial_subtractor #(
    parameter int N = 4
) (
    input logic               clk,
    input logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  partial;
    logic [N-1:0]  diff_r;
    logic [CW-1:0] count;
    logic          br;
    logic          bout_r;
    logic          busy_r;
    logic          done_r;

    logic          a0;
    logic          b0;
    logic          d;
    logic          bo;
    logic [N-1:0]  next_partial;

    // Full-subtractor cell on the current LSBs; each new bit enters at the MSB
    always_comb begin
        a0           = a_sr[0];
        b0           = b_sr[0];
        d            = a0 ^ b0 ^ br;
        bo           = (~a0 & b0) | (~(a0 ^ b0) & br);
        next_partial = partial >> 1;
        next_partial[N-1] = d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            partial <= '0;
            diff_r  <= '0;
            count   <= '0;
            br      <= 1'b0;
            bout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        br     <= bus.bin;
                        count  <= '0;
                        busy_r <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    partial <= next_partial;
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    br      <= bo;
                    count   <= count + 1'b1;
                    // Results are only published on the last bit so diff/bout stay stable mid-operation
                    if (count == LAST) begin
                        diff_r <= next_partial;
                        bout_r <= bo;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
endmodule
